// File: rtl/sync_decoder_pkg.sv
// Shared timing definitions for the LCD sync generators and the receive-side
// sync decoder, so both ends agree on nominal line/frame geometry.
package sync_decoder_pkg;

  // Nominal horizontal timing, in pixel clocks
  localparam int H_TOTAL     = 525;
  localparam int H_SYNC      = 41;
  localparam int H_ACT_START = 43;
  localparam int H_ACT       = 480;

  // Nominal vertical timing, in lines
  localparam int V_ACT_START = 12;
  localparam int V_ACT       = 272;

  // Consecutive good lines needed before declaring lock
  localparam int LOCK_LINES  = 4;

  // Coordinate widths
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_decoder_edge_meas.sv
// Sync edge detection and horizontal measurement: finds hsync/vsync falling
// edges, runs the column counter and measures the hsync low width so the
// top level can judge each line against nominal timing.
module sync_edge_meas
  import sync_decoder_pkg::*;
#(
  parameter int H_TOTAL = sync_decoder_pkg::H_TOTAL,
  parameter int H_SYNC  = sync_decoder_pkg::H_SYNC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hsync_in,
  input  logic           vsync_in,
  output logic           fall_h,
  output logic           fall_v,
  output logic [X_W-1:0] h_cnt,
  output logic           period_ok,
  output logic           width_ok
);

  localparam logic [X_W-1:0] PERIOD_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] SYNC_WIDTH  = X_W'(H_SYNC);

  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [X_W-1:0] lw_q, lw_d;

  // Edge detect, column counter and low-width counter next-state
  always_comb begin
    hs_d   = hsync_in;
    vs_d   = vsync_in;
    fall_h = hs_q & ~hsync_in;
    fall_v = vs_q & ~vsync_in;

    h_cnt_d = fall_h ? '0 : sat_inc_x(h_cnt_q);

    // The fall cycle itself is the first low cycle; the count then holds
    // from the rising edge until the next fall judges it.
    lw_d = lw_q;
    if (fall_h) begin
      lw_d = X_W'(1);
    end else if (!hsync_in) begin
      lw_d = sat_inc_x(lw_q);
    end

    // Both judgements describe the line that ends at this fall
    period_ok = (h_cnt_q == PERIOD_LAST);
    width_ok  = (lw_q == SYNC_WIDTH);
  end

  // Measurement registers; sync history idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      h_cnt_q <= '0;
      lw_q    <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      h_cnt_q <= h_cnt_d;
      lw_q    <= lw_d;
    end
  end

  assign h_cnt = h_cnt_q;

endmodule

// File: rtl/sync_decoder.sv
// Receive-side sync decoder: recovers pixel column, line number and the
// active-video qualifier from active-low hsync/vsync, and tracks line timing
// lock with a SEARCH/TRACK/LOCKED state machine.
module sync_decoder
  import sync_decoder_pkg::*;
#(
  parameter int H_TOTAL     = sync_decoder_pkg::H_TOTAL,
  parameter int H_SYNC      = sync_decoder_pkg::H_SYNC,
  parameter int H_ACT_START = sync_decoder_pkg::H_ACT_START,
  parameter int H_ACT       = sync_decoder_pkg::H_ACT,
  parameter int V_ACT_START = sync_decoder_pkg::V_ACT_START,
  parameter int V_ACT       = sync_decoder_pkg::V_ACT,
  parameter int LOCK_LINES  = sync_decoder_pkg::LOCK_LINES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hsync_in,
  input  logic           vsync_in,
  output logic           active,
  output logic [X_W-1:0] px_x,
  output logic [Y_W-1:0] px_y,
  output logic           line_start,
  output logic           frame_start,
  output logic           locked,
  output logic           err
);

  localparam int GC_W = $clog2(LOCK_LINES + 1);
  localparam logic [GC_W-1:0] GOOD_LAST = GC_W'(LOCK_LINES - 1);
  localparam logic [X_W-1:0]  X_LO      = X_W'(H_ACT_START);
  localparam logic [X_W-1:0]  X_HI      = X_W'(H_ACT_START + H_ACT);
  localparam logic [Y_W-1:0]  Y_LO      = Y_W'(V_ACT_START);
  localparam logic [Y_W-1:0]  Y_HI      = Y_W'(V_ACT_START + V_ACT);

  logic           fall_h, fall_v;
  logic [X_W-1:0] h_cnt;
  logic           period_ok, width_ok;

  sync_edge_meas #(
    .H_TOTAL (H_TOTAL),
    .H_SYNC  (H_SYNC)
  ) u_meas (
    .clk       (clk),
    .rst       (rst),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .fall_h    (fall_h),
    .fall_v    (fall_v),
    .h_cnt     (h_cnt),
    .period_ok (period_ok),
    .width_ok  (width_ok)
  );

  lock_state_e     state_q, state_d;
  logic [GC_W-1:0] good_q, good_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [Y_W-1:0]  v_cnt_q, v_cnt_d;
  logic            vpend_q, vpend_d;
  logic            frame_start_q, frame_start_d;
  logic            line_start_q, line_start_d;
  logic            active_q, active_d;
  logic [X_W-1:0]  px_x_q, px_x_d;
  logic [Y_W-1:0]  px_y_q, px_y_d;
  logic            line_good, h_timeout, h_in, v_in;

  // Lock state machine next-state: lines are judged at each hsync fall,
  // and a saturated column counter means sync has vanished
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    line_good = period_ok & width_ok;
    h_timeout = &h_cnt;

    if (fall_h) begin
      unique case (state_q)
        SEARCH: begin
          // First fall is only a phase reference, not judged
          state_d = TRACK;
          good_d  = '0;
        end
        TRACK: begin
          if (line_good) begin
            good_d = good_q + 1'b1;
            if (good_q == GOOD_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!line_good) begin
            state_d  = SEARCH;
            locked_d = 1'b0;
            err_d    = 1'b1;
            good_d   = '0;
          end
        end
        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          good_d   = '0;
        end
      endcase
    end else if (h_timeout) begin
      err_d    = (state_q == LOCKED);
      state_d  = SEARCH;
      locked_d = 1'b0;
      good_d   = '0;
    end
  end

  // Lock state machine registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // Line counter: a vsync fall arms a frame restart taken at the next hsync
  // fall, including a vsync fall in the same cycle as that hsync fall
  always_comb begin
    v_cnt_d       = v_cnt_q;
    vpend_d       = vpend_q;
    frame_start_d = 1'b0;
    if (fall_h) begin
      if (vpend_q | fall_v) begin
        v_cnt_d       = '0;
        frame_start_d = 1'b1;
        vpend_d       = 1'b0;
      end else begin
        v_cnt_d = sat_inc_y(v_cnt_q);
      end
    end else if (fall_v) begin
      vpend_d = 1'b1;
    end
  end

  // Output qualifiers and coordinates; subtraction wraps freely because
  // the result is forced to zero outside the active window
  always_comb begin
    h_in         = (h_cnt >= X_LO) && (h_cnt < X_HI);
    v_in         = (v_cnt_q >= Y_LO) && (v_cnt_q < Y_HI);
    active_d     = locked_q & h_in & v_in;
    px_x_d       = active_d ? (h_cnt - X_LO) : '0;
    px_y_d       = active_d ? (v_cnt_q - Y_LO) : '0;
    line_start_d = fall_h;
  end

  // Vertical state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      v_cnt_q       <= '0;
      vpend_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      active_q      <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
    end else begin
      v_cnt_q       <= v_cnt_d;
      vpend_q       <= vpend_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      active_q      <= active_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
    end
  end

  assign active      = active_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule
